// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU, debug and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(parameter int AW = 12);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wmask;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic [3:0]    dbg_wmask;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wmask, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wmask, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU-priority single-port memory arbiter with debug starvation guard and lock; ARB_STATS_EN adds a conflict counter
module mem_port_arbiter #(
  parameter int AW       = 12,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic [15:0]          stat_conflicts
);
  typedef enum logic {OPEN, DBG_LOCKED} state_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_t            state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic [RD_LAT-1:0] vld_q, vld_d, own_q, own_d;
  logic              cpu_g, dbg_g, starve_hit, cpu_rv, dbg_rv;
  always_comb begin
    starve_hit = bus.dbg_req && starve_q == MW;
    cpu_g      = reset && state_q == OPEN && bus.cpu_req && !starve_hit;
    dbg_g      = reset && bus.dbg_req && !cpu_g;
    state_d    = (state_q == DBG_LOCKED || dbg_g) && bus.dbg_lock ? DBG_LOCKED : OPEN;
    starve_d   = dbg_g ? 8'd0 : (bus.dbg_req && !starve_hit) ? starve_q + 8'd1 : starve_q;
    // tag shift: bit 0 takes this cycle's read, top bit is the one returning now
    vld_d      = RD_LAT'({vld_q, (cpu_g && !bus.cpu_we) || (dbg_g && !bus.dbg_we)});
    own_d      = RD_LAT'({own_q, dbg_g});
    cpu_rv     = reset && vld_q[RD_LAT-1] && !own_q[RD_LAT-1];
    dbg_rv     = reset && vld_q[RD_LAT-1] && own_q[RD_LAT-1];
  end
  assign bus.cpu_gnt    = cpu_g;
  assign bus.dbg_gnt    = dbg_g;
  assign bus.mem_en     = cpu_g || dbg_g;
  assign bus.mem_we     = cpu_g ? bus.cpu_we : dbg_g && bus.dbg_we;
  assign bus.mem_addr   = cpu_g ? bus.cpu_addr : dbg_g ? bus.dbg_addr : AW'(0);
  assign bus.mem_wdata  = cpu_g ? bus.cpu_wdata : dbg_g ? bus.dbg_wdata : 32'd0;
  assign bus.mem_wmask  = cpu_g ? bus.cpu_wmask : dbg_g ? bus.dbg_wmask : 4'd0;
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.dbg_rvalid = dbg_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : 32'd0;
  assign bus.dbg_rdata  = dbg_rv ? bus.mem_rdata : 32'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OPEN;
      starve_q <= '0;
      vld_q    <= '0;
      own_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
    end
  end
`ifdef ARB_STATS_EN
  logic [15:0] conf_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conf_q <= '0;
    else if (bus.cpu_req && bus.dbg_req && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
  end
  assign stat_conflicts = conf_q;
`else
  assign stat_conflicts = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (RD_LAT 1 and 2) on shared stimulus, checked against a schedule-based model
module tb_mem_port_arbiter;
  localparam int MAXW = 8;
  logic clk = 0, reset = 0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [11:0] cpu_addr = 0, dbg_addr = 0;
  logic [31:0] cpu_wdata = 0, dbg_wdata = 0;
  logic [3:0] cpu_wmask = 0, dbg_wmask = 0;
  logic [15:0] st1, st2;
  int passed = 0, total = 0, cyc = 0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(12)) i1();
  mem_port_arbiter_if #(.AW(12)) i2();
  mem_port_arbiter #(.AW(12), .RD_LAT(1), .MAX_WAIT(MAXW)) dut1 (.clk(clk), .reset(reset), .bus(i1), .stat_conflicts(st1));
  mem_port_arbiter #(.AW(12), .RD_LAT(2), .MAX_WAIT(MAXW)) dut2 (.clk(clk), .reset(reset), .bus(i2), .stat_conflicts(st2));

  assign i1.cpu_req = cpu_req;   assign i2.cpu_req = cpu_req;
  assign i1.cpu_we = cpu_we;     assign i2.cpu_we = cpu_we;
  assign i1.cpu_addr = cpu_addr; assign i2.cpu_addr = cpu_addr;
  assign i1.cpu_wdata = cpu_wdata; assign i2.cpu_wdata = cpu_wdata;
  assign i1.cpu_wmask = cpu_wmask; assign i2.cpu_wmask = cpu_wmask;
  assign i1.dbg_req = dbg_req;   assign i2.dbg_req = dbg_req;
  assign i1.dbg_we = dbg_we;     assign i2.dbg_we = dbg_we;
  assign i1.dbg_addr = dbg_addr; assign i2.dbg_addr = dbg_addr;
  assign i1.dbg_wdata = dbg_wdata; assign i2.dbg_wdata = dbg_wdata;
  assign i1.dbg_wmask = dbg_wmask; assign i2.dbg_wmask = dbg_wmask;
  assign i1.dbg_lock = dbg_lock; assign i2.dbg_lock = dbg_lock;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return a == 12'h010 ? 32'h00500093 : 32'hC0DE0000 ^ {20'd0, a};
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // memory behind each DUT; unwritten words read their initial pattern
  logic [31:0] tmem [2][4096];
  bit wrf [2][4096];
  logic [31:0] rp1, rp2a, rp2b;
  always @(posedge clk) begin
    if (i1.mem_en && i1.mem_we) begin
      tmem[0][i1.mem_addr] <= merge(wrf[0][i1.mem_addr] ? tmem[0][i1.mem_addr] : init_val(i1.mem_addr), i1.mem_wdata, i1.mem_wmask);
      wrf[0][i1.mem_addr] <= 1'b1;
    end
    rp1 <= (i1.mem_en && !i1.mem_we) ? (wrf[0][i1.mem_addr] ? tmem[0][i1.mem_addr] : init_val(i1.mem_addr)) : 32'hDEADBEEF;
  end
  always @(posedge clk) begin
    if (i2.mem_en && i2.mem_we) begin
      tmem[1][i2.mem_addr] <= merge(wrf[1][i2.mem_addr] ? tmem[1][i2.mem_addr] : init_val(i2.mem_addr), i2.mem_wdata, i2.mem_wmask);
      wrf[1][i2.mem_addr] <= 1'b1;
    end
    rp2a <= (i2.mem_en && !i2.mem_we) ? (wrf[1][i2.mem_addr] ? tmem[1][i2.mem_addr] : init_val(i2.mem_addr)) : 32'hDEADBEEF;
    rp2b <= rp2a;
  end
  assign i1.mem_rdata = rp1;
  assign i2.mem_rdata = rp2b;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
  endtask

  // model: expected returns are scheduled into a per-cycle slot table at grant time
  int waited [2];
  bit locked [2];
  int conf [2];
  int lat [2] = '{1, 2};
  logic [31:0] sh [2][4096];
  bit sv [2][8];
  bit so [2][8];
  logic [31:0] sd [2][8];
  initial for (int k = 0; k < 2; k++) for (int i = 0; i < 4096; i++) sh[k][i] = init_val(12'(i));

  task automatic model_cmp(input int k, input logic cg_o, dg_o, en_o, we_o, input logic [11:0] a_o,
                           input logic [31:0] wd_o, input logic [3:0] wm_o, input logic cv_o,
                           input logic [31:0] crd_o, input logic dv_o, input logic [31:0] drd_o,
                           input logic [15:0] st_o);
    bit cg = 0, dg = 0, rv = 0, ro = 0, we;
    logic [11:0] a;
    logic [31:0] wd, rd = 0;
    logic [3:0] wm;
    int s = cyc % 8;
    if (!reset) begin
      locked[k] = 0; waited[k] = 0; conf[k] = 0;
      for (int j = 0; j < 8; j++) sv[k][j] = 0;
    end else begin
      if (locked[k]) dg = dbg_req;
      else if (dbg_req && waited[k] >= MAXW) dg = 1;
      else if (cpu_req) cg = 1;
      else dg = dbg_req;
      rv = sv[k][s]; ro = so[k][s]; rd = sd[k][s]; sv[k][s] = 0;
    end
    we = cg ? cpu_we : dg & dbg_we;
    a  = cg ? cpu_addr : dg ? dbg_addr : 12'd0;
    wd = cg ? cpu_wdata : dg ? dbg_wdata : 32'd0;
    wm = cg ? cpu_wmask : dg ? dbg_wmask : 4'd0;
    chk("grants", k, {30'd0, cg_o, dg_o}, {30'd0, cg, dg});
    chk("mem_en", k, en_o, cg | dg);
    chk("mem_we", k, we_o, we);
    chk("mem_addr", k, a_o, a);
    chk("mem_wdata", k, wd_o, wd);
    chk("mem_wmask", k, wm_o, wm);
    chk("cpu_rvalid", k, cv_o, rv && !ro);
    chk("dbg_rvalid", k, dv_o, rv && ro);
    chk("cpu_rdata", k, crd_o, (rv && !ro) ? rd : 32'd0);
    chk("dbg_rdata", k, drd_o, (rv && ro) ? rd : 32'd0);
`ifdef ARB_STATS_EN
    chk("stat", k, st_o, conf[k]);
`else
    chk("stat", k, st_o, 0);
`endif
    if (reset) begin
      if (cg | dg) begin
        if (we) sh[k][a] = merge(sh[k][a], wd, wm);
        else begin
          sv[k][(cyc + lat[k]) % 8] = 1;
          so[k][(cyc + lat[k]) % 8] = dg;
          sd[k][(cyc + lat[k]) % 8] = sh[k][a];
        end
      end
      waited[k] = dg ? 0 : dbg_req ? (waited[k] < MAXW ? waited[k] + 1 : MAXW) : waited[k];
      locked[k] = (locked[k] || dg) && dbg_lock;
      if (cpu_req && dbg_req && conf[k] < 65535) conf[k]++;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    model_cmp(0, i1.cpu_gnt, i1.dbg_gnt, i1.mem_en, i1.mem_we, i1.mem_addr, i1.mem_wdata, i1.mem_wmask,
              i1.cpu_rvalid, i1.cpu_rdata, i1.dbg_rvalid, i1.dbg_rdata, st1);
    model_cmp(1, i2.cpu_gnt, i2.dbg_gnt, i2.mem_en, i2.mem_we, i2.mem_addr, i2.mem_wdata, i2.mem_wmask,
              i2.cpu_rvalid, i2.cpu_rdata, i2.dbg_rvalid, i2.dbg_rdata, st2);
  end

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wmask = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_wmask = 0; dbg_lock = 0;
  endtask
  task automatic tick(); @(negedge clk); endtask
  task automatic adv(); @(posedge clk); #1; endtask

  bit t4_cv [7] = '{0, 0, 1, 0, 0, 1, 0};
  bit t4_dv [7] = '{0, 0, 0, 1, 0, 0, 0};
  logic [31:0] t4_d [7] = '{0, 0, 32'hC0DE0060, 32'hD0000002, 0, 32'hC0DE5678, 0};

  initial begin
    idle();
    repeat (3) begin tick(); adv(); end
    reset = 1;
    tick(); chk("rst_stat", 0, st1, 0); chk("rst_gnt", 0, i1.cpu_gnt, 0); adv();
    // single CPU read, data returns after each DUT's latency
    cpu_req = 1; cpu_addr = 12'h010;
    tick(); chk("t1_gnt", 0, i1.cpu_gnt, 1); chk("t1_addr", 0, i1.mem_addr, 32'h010); adv();
    idle();
    tick(); chk("t1_rv", 0, i1.cpu_rvalid, 1); chk("t1_rd", 0, i1.cpu_rdata, 32'h00500093);
    chk("t1_dbgrv", 0, i1.dbg_rvalid, 0); chk("t1_rv_early", 1, i2.cpu_rvalid, 0); adv();
    tick(); chk("t1_rv2", 1, i2.cpu_rvalid, 1); chk("t1_rd2", 1, i2.cpu_rdata, 32'h00500093);
    chk("t1_rv_once", 0, i1.cpu_rvalid, 0); adv();
    // both requesting: CPU 8 times, debug on the 9th
    cpu_req = 1; cpu_addr = 12'h020; dbg_req = 1; dbg_addr = 12'h030;
    for (int k = 1; k <= 9; k++) begin
      tick(); chk("t2_cg", 0, i1.cpu_gnt, k != 9); chk("t2_dg", 0, i1.dbg_gnt, k == 9); adv();
    end
    dbg_req = 0;
    tick(); chk("t2_resume", 0, i1.cpu_gnt, 1); adv();
    idle(); repeat (3) begin tick(); adv(); end
    // locked debug burst while the CPU keeps requesting
    cpu_req = 1; cpu_addr = 12'h050;
    dbg_req = 1; dbg_we = 1; dbg_wmask = 4'hF; dbg_addr = 12'h100; dbg_wdata = 32'hD0000000; dbg_lock = 1;
    for (int k = 1; k <= 8; k++) begin tick(); chk("t3_wait", 0, i1.cpu_gnt, 1); adv(); end
    for (int b = 0; b < 4; b++) begin
      dbg_addr = 12'h100 + 12'(b); dbg_wdata = 32'hD0000000 + b; dbg_lock = (b != 3);
      tick(); chk("t3_cg", 0, i1.cpu_gnt, 0); chk("t3_dg", 0, i1.dbg_gnt, 1);
      chk("t3_wd", 0, i1.mem_wdata, 32'hD0000000 + b); chk("t3_addr", 0, i1.mem_addr, 32'h100 + b); adv();
    end
    dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    tick(); chk("t3_cpu_back", 0, i1.cpu_gnt, 1); adv();
    idle(); dbg_req = 1; dbg_addr = 12'h102;
    tick(); adv(); idle();
    tick(); chk("t3_readback", 0, i1.dbg_rdata, 32'hD0000002); adv();
    tick(); adv();
    // interleaved owners, checked on the RD_LAT=2 instance
    for (int t = 0; t < 7; t++) begin
      cpu_req = (t == 0 || t == 2 || t == 3); cpu_we = (t == 2);
      cpu_addr = (t == 0) ? 12'h060 : 12'h061; cpu_wdata = 32'h12345678; cpu_wmask = 4'b0011;
      dbg_req = (t == 1); dbg_addr = 12'h102;
      tick();
      chk("t4_cv", 1, i2.cpu_rvalid, t4_cv[t]); chk("t4_dv", 1, i2.dbg_rvalid, t4_dv[t]);
      chk("t4_crd", 1, i2.cpu_rdata, t4_cv[t] ? t4_d[t] : 32'd0);
      chk("t4_drd", 1, i2.dbg_rdata, t4_dv[t] ? t4_d[t] : 32'd0);
      adv();
    end
    idle();
    // read in flight dropped by reset
    cpu_req = 1; cpu_addr = 12'h070;
    tick(); adv();
    reset = 0; dbg_req = 1;
    tick(); chk("t5_gnt", 0, {i1.cpu_gnt, i1.dbg_gnt, i1.mem_en}, 0); chk("t5_rv", 0, i1.cpu_rvalid, 0); adv();
    tick(); adv();
    reset = 1; idle();
    repeat (3) begin
      tick(); chk("t5_rv1", 0, i1.cpu_rvalid, 0); chk("t5_rv2", 1, i2.cpu_rvalid, 0); chk("t5_stat", 0, st1, 0); adv();
    end
    // conflict counting
    cpu_req = 1; cpu_addr = 12'h080; dbg_req = 1; dbg_addr = 12'h090;
    repeat (5) begin tick(); chk("t6_cg", 0, i1.cpu_gnt, 1); chk("t6_dg", 0, i1.dbg_gnt, 0); adv(); end
    idle();
`ifdef ARB_STATS_EN
    tick(); chk("t6_stat", 0, st1, 5); adv();
`else
    tick(); chk("t6_stat", 0, st1, 0); adv();
`endif
    repeat (3) begin tick(); adv(); end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
